pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 53 +++++
 rtl/branch_lut.sv | 32 +++
 rtl/pc_seq_checker.sv | 28 ++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types, instruction field positions and branch-LUT defaults for the
// program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam int INSTR_W   = 9;
    localparam int BR_BIT    = 6;
    localparam int LUT_HI    = 5;
    localparam int LUT_LO    = 3;
    localparam int MEM_BIT   = 8;
    localparam int LUT_AW    = LUT_HI - LUT_LO + 1;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    localparam int DEF_OFF_FWD  = 2;
    localparam int DEF_OFF_BACK = -2;
    localparam int DEF_OFF_STEP = 1;

    typedef struct packed {
        logic              is_halt;
        logic              is_branch;
        logic              is_mem;
        logic [LUT_AW-1:0] lut_idx;
    } decode_t;

    // Entry 0 jumps forward over one word, entry 7 loops back, the rest step.
    function automatic int lut_default(input int idx);
        int off;
        case (idx)
            0:       off = DEF_OFF_FWD;
            7:       off = DEF_OFF_BACK;
            default: off = DEF_OFF_STEP;
        endcase
        return off;
    endfunction

    function automatic decode_t decode(input logic [INSTR_W-1:0] instr);
        decode_t d;
        d.is_halt   = (instr == HALT_INSTR);
        d.is_branch = instr[BR_BIT];
        d.is_mem    = instr[MEM_BIT] & ~instr[BR_BIT];
        d.lut_idx   = instr[LUT_HI:LUT_LO];
        return d;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Programmable table of signed branch offsets: synchronous write, asynchronous
// read, restored to its default offsets by init.
module branch_lut
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic              CLK,
    input  logic              init,
    input  logic              we,
    input  logic [LUT_AW-1:0] wr_addr,
    input  logic [PC_W-1:0]   wr_data,
    input  logic [LUT_AW-1:0] rd_addr,
    output logic [PC_W-1:0]   rd_data
);

    logic [PC_W-1:0] lut_r [LUT_DEPTH];

    // Table storage: defaults on init, otherwise a single-entry write.
    always_ff @(posedge CLK) begin
        if (init) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_r[i] <= PC_W'(lut_default(i));
            end
        end else if (we) begin
            lut_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = lut_r[rd_addr];

endmodule

// File: rtl/pc_seq_checker.sv
// Invariants tying the registered status outputs to the sequencer state.
module pc_seq_checker
    import pc_seq_pkg::*;
(
    input logic   CLK,
    input logic   init,
    input state_e state,
    input logic   mem_req,
    input logic   busy,
    input logic   halt,
    input logic   err
);

    // Sampled only once init has been released.
    always @(posedge CLK) begin
        if (!init) begin
            assert (mem_req == (state == MEM_WAIT))
                else $error("pc_seq_checker: mem_req out of step with state");
            assert (halt == (state == HALT))
                else $error("pc_seq_checker: halt out of step with state");
            assert (!(halt && busy))
                else $error("pc_seq_checker: busy while halted");
            assert (!err || halt)
                else $error("pc_seq_checker: err without halt");
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/branch controller: owns the program counter, resolves branches via the
// offset LUT, stalls on data-memory handshakes and latches halt/error.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int MAX_PC      = 1023,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               init,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               EQUAL,
    input  logic               mem_ack,
    input  logic               lut_we,
    input  logic [LUT_AW-1:0]  lut_addr,
    input  logic [PC_W-1:0]    lut_data,
    output logic [PC_W-1:0]    PC,
    output logic               mem_req,
    output logic               busy,
    output logic               halt,
    output logic               err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e          state_r;
    logic [CNT_W-1:0] cnt_r;

    decode_t         dec_s;
    logic            taken_s;
    logic            at_max_s;
    logic            lut_we_s;
    logic [PC_W-1:0] lut_off_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] pc_br_s;

    assign dec_s    = decode(instruction);
    assign taken_s  = dec_s.is_branch & EQUAL;
    assign at_max_s = (PC == PC_W'(MAX_PC));
    assign lut_we_s = lut_we & (state_r == IDLE);
    // Offsets are PC_W wide, so the sum wraps modulo 2^PC_W by construction.
    assign pc_inc_s = PC + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_br_s  = PC + lut_off_s;
    assign busy     = (state_r == RUN) | (state_r == MEM_WAIT);

    branch_lut #(
        .PC_W (PC_W)
    ) u_lut (
        .CLK     (CLK),
        .init    (init),
        .we      (lut_we_s),
        .wr_addr (lut_addr),
        .wr_data (lut_data),
        .rd_addr (dec_s.lut_idx),
        .rd_data (lut_off_s)
    );

    // Sequencer FSM with the PC and all status outputs registered.
    always_ff @(posedge CLK) begin
        if (init) begin
            state_r <= IDLE;
            PC      <= {PC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            mem_req <= 1'b0;
            halt    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (dec_s.is_halt) begin
                        state_r <= HALT;
                        halt    <= 1'b1;
                    end else if (taken_s) begin
                        PC <= pc_br_s;
                    end else if (at_max_s) begin
                        // Nothing may step past the last legal address.
                        state_r <= HALT;
                        halt    <= 1'b1;
                    end else if (dec_s.is_branch) begin
                        PC <= pc_inc_s;
                    end else if (dec_s.is_mem) begin
                        mem_req <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= MEM_WAIT;
                    end else begin
                        PC <= pc_inc_s;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (at_max_s) begin
                            state_r <= HALT;
                            halt    <= 1'b1;
                        end else begin
                            PC      <= pc_inc_s;
                            state_r <= RUN;
                        end
                    end else if (cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        halt    <= 1'b1;
                        state_r <= HALT;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                HALT: begin
                    halt    <= 1'b1;
                    mem_req <= 1'b0;
                end
                default: begin
                    state_r <= HALT;
                    halt    <= 1'b1;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    pc_seq_checker u_chk (
        .CLK     (CLK),
        .init    (init),
        .state   (state_r),
        .mem_req (mem_req),
        .busy    (busy),
        .halt    (halt),
        .err     (err)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each step queues the expected
// outputs, clocks once and compares PC/mem_req/busy/halt/err.
module tb_pc_sequencer;

    logic       CLK         = 1'b0;
    logic       init        = 1'b1;
    logic       start       = 1'b0;
    logic [8:0] instruction = 9'h000;
    logic       EQUAL       = 1'b0;
    logic       mem_ack     = 1'b0;
    logic       lut_we      = 1'b0;
    logic [2:0] lut_addr    = 3'd0;
    logic [9:0] lut_data    = 10'd0;
    logic [9:0] PC;
    logic       mem_req;
    logic       busy;
    logic       halt;
    logic       err;

    localparam logic [8:0] NOP = 9'h000;
    localparam logic [8:0] MEM = 9'h100;
    localparam logic [8:0] HLT = 9'h1FF;

    typedef struct {
        string      tag;
        logic [9:0] pc;
        logic       req;
        logic       bsy;
        logic       hlt;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    pc_sequencer dut (
        .CLK         (CLK),
        .init        (init),
        .start       (start),
        .instruction (instruction),
        .EQUAL       (EQUAL),
        .mem_ack     (mem_ack),
        .lut_we      (lut_we),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .PC          (PC),
        .mem_req     (mem_req),
        .busy        (busy),
        .halt        (halt),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] br(input logic [2:0] idx);
        return 9'h040 | {3'b000, idx, 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [9:0] epc, input logic ereq, input logic ebsy,
                        input logic ehlt, input logic eer, input string tag);
        exp_t e;
        e.tag = tag; e.pc = epc; e.req = ereq; e.bsy = ebsy; e.hlt = ehlt; e.er = eer;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},      PC,               e.pc);
        chk({e.tag, ".mem_req"}, {9'd0, mem_req},  {9'd0, e.req});
        chk({e.tag, ".busy"},    {9'd0, busy},     {9'd0, e.bsy});
        chk({e.tag, ".halt"},    {9'd0, halt},     {9'd0, e.hlt});
        chk({e.tag, ".err"},     {9'd0, err},      {9'd0, e.er});
    endtask

    task automatic do_reset();
        start = 1'b0; EQUAL = 1'b0; mem_ack = 1'b0; lut_we = 1'b0; instruction = NOP;
        init = 1'b1;
        tick(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        init = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(10'd0, 1'b0, 1'b1, 1'b0, 1'b0, "start");
        start = 1'b0;
    endtask

    task automatic nops(input int n, input int first_pc);
        instruction = NOP;
        for (int k = 0; k < n; k++) begin
            tick(10'(first_pc + k + 1), 1'b0, 1'b1, 1'b0, 1'b0, "nop_step");
        end
    endtask

    initial begin
        // Basic stepping and branch resolution with default offsets
        do_reset();
        go();
        nops(5, 0);
        mem_ack = 1'b1;
        nops(5, 5);
        mem_ack = 1'b0;
        instruction = br(3'd0); EQUAL = 1'b1;
        tick(10'd12, 1'b0, 1'b1, 1'b0, 1'b0, "br0_taken");
        instruction = br(3'd7);
        tick(10'd10, 1'b0, 1'b1, 1'b0, 1'b0, "br7_taken");
        instruction = 9'h140; EQUAL = 1'b0;
        tick(10'd11, 1'b0, 1'b1, 1'b0, 1'b0, "br0_not_taken");

        // LUT programming in IDLE, ignored write in RUN, wrap and end-of-space halt
        do_reset();
        lut_we = 1'b1; lut_addr = 3'd3; lut_data = 10'h3FB;
        tick(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lut_wr_idle");
        lut_we = 1'b0;
        go();
        nops(1, 0);
        lut_we = 1'b1; lut_addr = 3'd3; lut_data = 10'd7;
        tick(10'd2, 1'b0, 1'b1, 1'b0, 1'b0, "lut_wr_run");
        lut_we = 1'b0;
        instruction = br(3'd3); EQUAL = 1'b1;
        tick(10'd1021, 1'b0, 1'b1, 1'b0, 1'b0, "br3_wrap");
        EQUAL = 1'b0;
        nops(2, 1021);
        tick(10'd1023, 1'b0, 1'b0, 1'b1, 1'b0, "max_pc_halt");
        tick(10'd1023, 1'b0, 1'b0, 1'b1, 1'b0, "max_pc_hold");

        // Memory op acknowledged on the third wait cycle
        do_reset();
        go();
        nops(4, 0);
        instruction = MEM;
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "mem_issue");
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "mem_wait1");
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "mem_wait2");
        mem_ack = 1'b1;
        tick(10'd5, 1'b0, 1'b1, 1'b0, 1'b0, "mem_ack");
        mem_ack = 1'b0;
        nops(1, 5);

        // Memory timeout
        do_reset();
        go();
        nops(4, 0);
        instruction = MEM;
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "to_issue");
        for (int k = 0; k < 14; k++) begin
            tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "to_wait");
        end
        tick(10'd4, 1'b0, 1'b0, 1'b1, 1'b1, "timeout");

        // Ack on the timeout cycle wins
        do_reset();
        go();
        nops(4, 0);
        instruction = MEM;
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "race_issue");
        for (int k = 0; k < 14; k++) begin
            tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "race_wait");
        end
        mem_ack = 1'b1;
        tick(10'd5, 1'b0, 1'b1, 1'b0, 1'b0, "race_ack_wins");
        mem_ack = 1'b0;

        // HALT instruction, start ignored, init recovers
        do_reset();
        go();
        nops(7, 0);
        instruction = HLT; EQUAL = 1'b1;
        tick(10'd7, 1'b0, 1'b0, 1'b1, 1'b0, "halt_instr");
        EQUAL = 1'b0; start = 1'b1;
        tick(10'd7, 1'b0, 1'b0, 1'b1, 1'b0, "halt_start_ignored");
        start = 1'b0;
        do_reset();
        tick(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_init");

        // init in the middle of a handshake restores the LUT too
        lut_we = 1'b1; lut_addr = 3'd0; lut_data = 10'd5;
        tick(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lut_wr0");
        lut_we = 1'b0;
        go();
        nops(4, 0);
        instruction = MEM;
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "mid_issue");
        tick(10'd4, 1'b1, 1'b1, 1'b0, 1'b0, "mid_wait");
        init = 1'b1;
        tick(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, "init_mid_mem");
        init = 1'b0;
        go();
        nops(10, 0);
        instruction = br(3'd0); EQUAL = 1'b1;
        tick(10'd12, 1'b0, 1'b1, 1'b0, 1'b0, "lut_restored");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
